wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
Wishbone classic master that turns single-beat command requests into Wishbone bus cycles toward the user project wrapper's slave port, including the debug register window at 0x300FFFF8–0x300FFFFF. It is the initiator counterpart to the wrapper's responder logic. It is used by the FPGA-side test harness and housekeeping paths to read and write user and debug registers. Each command yields exactly one response, carrying read data or a timeout error.

Parameters:
TIMEOUT_CYCLES, 256, max cycles a bus cycle may wait for ack before abort; 0 disables the timeout.
TIMEOUT_DATA, 32'hDEADBEEF, value returned on rsp_dat when a cycle times out.
CNT_W, 16, width of the completed-transaction counter.

Ports:
wb_clk_i  in  1  single clock; all logic is rising-edge.
wb_rst_i  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_we  in  1  1 = write, 0 = read.
cmd_sel  in  4  byte selects.
cmd_adr  in  32  byte address.
cmd_dat  in  32  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_dat  out  32  read data, 0 for writes, TIMEOUT_DATA on timeout.
rsp_err  out  1  1 = cycle timed out.
wbm_cyc_o  out  1  Wishbone cycle.
wbm_stb_o  out  1  Wishbone strobe.
wbm_we_o  out  1  Wishbone write enable.
wbm_sel_o  out  4  Wishbone byte selects.
wbm_adr_o  out  32  Wishbone address.
wbm_dat_o  out  32  Wishbone write data.
wbm_ack_i  in  1  Wishbone acknowledge.
wbm_dat_i  in  32  Wishbone read data.
busy  out  1  high in any state other than IDLE.
txn_count  out  CNT_W  number of completed transactions (ack or timeout).

Behaviour:
- Reset (wb_rst_i high at an edge): all outputs go to 0, state goes to IDLE, and timeout and txn counters clear.
  - A reset mid-cycle drops cyc/stb at that edge. No response is produced for the abandoned command.
- All bus outputs are registered.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge N, latch we/sel/adr/dat onto the wbm_* outputs and enter BUS. cyc = stb = 1 from N+1.
  - cmd_adr is passed through unmodified.
  - When the command is a read, wbm_dat_o = 0.
- BUS:
  - cmd_ready = 0. cyc/stb stay high and all wbm_* outputs stay stable.
  - The timeout counter starts at 0 and increments each BUS cycle without ack.
  - If wbm_ack_i = 1 at edge M:
    - cyc/stb drop at M.
    - rsp_dat = wbm_dat_i for a read, 0 for a write.
    - rsp_err = 0, txn_count increments, state goes to RESP.
    - rsp_valid = 1 from M+1.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES > 0):
    - cyc/stb drop, rsp_dat = TIMEOUT_DATA, rsp_err = 1, txn_count increments, state goes to RESP.
    - cyc is therefore high for exactly TIMEOUT_CYCLES cycles.
  - If ack arrives on the same cycle as the timeout expiry, ack wins (rsp_err = 0).
- RESP:
  - rsp_valid = 1. rsp_dat and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid drops next edge, state goes to IDLE, and cmd_ready returns to 1 on the following cycle.
  - No command overlap: at most one outstanding transaction.
- wbm_ack_i in IDLE or RESP is ignored; no state or counter change.
- Latency:
  - For a slave acking one cycle after stb, cmd accept to rsp_valid is 3 edges.
  - Minimum command-to-command spacing is 4 cycles with rsp_ready held high.
- txn_count wraps from 2^CNT_W-1 to 0.
- busy = (state != IDLE).

Test Plan:
1. Write cmd adr=0x300FFFF8, dat=0xA5A5_1234, sel=4'hF; slave acks 1 cycle after stb -> wbm_adr_o=0x300FFFF8, wbm_we_o=1 for exactly the cyc window; rsp_valid with rsp_dat=0, rsp_err=0; txn_count=1.
2. Read cmd adr=0x300FFFFC; slave acks after 3 wait cycles with dat_i=0x0000_00C3 -> cyc high 4 cycles; rsp_dat=0x000000C3, rsp_err=0.
3. Read cmd to an unmapped user address with no ack, TIMEOUT_CYCLES=256 -> cyc high exactly 256 cycles then 0; rsp_dat=0xDEADBEEF, rsp_err=1; txn_count increments.
4. Ack asserted on the same cycle the timeout expires -> rsp_err=0 and rsp_dat=wbm_dat_i. Separately, a stray ack in IDLE -> no rsp_valid and txn_count unchanged.
5. Hold rsp_ready=0 for 10 cycles after a response, with cmd_valid held high -> rsp_valid/rsp_dat stable, cmd_ready=0, no new cyc. Release -> next command accepted one cycle later.
6. Assert wb_rst_i during BUS after 2 wait cycles -> cyc/stb/busy=0 at the reset edge, no rsp_valid ever for that command, txn_count=0. A new command completes normally afterwards.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: one command in, one bus cycle out, one response back.
// Bus cycles that never see an ack are aborted and reported as errors.
module wb_cmd_master #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
  parameter int          CNT_W          = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [3:0]       cmd_sel,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state;
  logic             r_cyc, w_cyc;
  logic             r_we, w_we;
  logic [3:0]       r_sel, w_sel;
  logic [31:0]      r_adr, w_adr;
  logic [31:0]      r_dat, w_dat;
  logic             r_rsp_valid, w_rsp_valid;
  logic [31:0]      r_rsp_dat, w_rsp_dat;
  logic             r_rsp_err, w_rsp_err;
  logic [TW-1:0]    r_tmo, w_tmo;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             w_expire;

  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_LAST);

  always_comb begin
    w_state     = r_state;
    w_cyc       = r_cyc;
    w_we        = r_we;
    w_sel       = r_sel;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_rsp_valid = r_rsp_valid;
    w_rsp_dat   = r_rsp_dat;
    w_rsp_err   = r_rsp_err;
    w_tmo       = r_tmo;
    w_cnt       = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state = S_BUS;
          w_cyc   = 1'b1;
          w_we    = cmd_we;
          w_sel   = cmd_sel;
          w_adr   = cmd_adr;
          w_dat   = cmd_we ? cmd_dat : '0;
          w_tmo   = '0;
        end
      end
      S_BUS: begin
        // ack takes priority over a timeout expiring on the same edge
        if (wbm_ack_i) begin
          w_state     = S_RESP;
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = r_we ? '0 : wbm_dat_i;
          w_rsp_err   = 1'b0;
          w_cnt       = r_cnt + 1'b1;
        end else if (w_expire) begin
          w_state     = S_RESP;
          w_cyc       = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_dat   = TIMEOUT_DATA;
          w_rsp_err   = 1'b1;
          w_cnt       = r_cnt + 1'b1;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_valid = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_tmo       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_cyc       <= w_cyc;
      r_we        <= w_we;
      r_sel       <= w_sel;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_dat   <= w_rsp_dat;
      r_rsp_err   <= w_rsp_err;
      r_tmo       <= w_tmo;
      r_cnt       <= w_cnt;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign txn_count = r_cnt;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: writes, reads, timeouts,
// back-pressure and mid-cycle reset.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dato;
  logic        ack;
  logic [31:0] dati;
  logic        busy;
  logic [15:0] txn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cmd_master dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dato),
    .wbm_ack_i(ack),
    .wbm_dat_i(dati),
    .busy     (busy),
    .txn_count(txn)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one command, then acks after 'waits' cycles of cyc (if ack_en).
  task automatic run_cmd(
    input  logic        c_we,
    input  logic [3:0]  c_sel,
    input  logic [31:0] c_adr,
    input  logic [31:0] c_dat,
    input  int          waits,
    input  bit          ack_en,
    input  logic [31:0] ack_dat,
    output int          cyc_len,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat,
    output bit          stable
  );
    int w;
    w = waits;
    cmd_valid = 1'b1;
    cmd_we    = c_we;
    cmd_sel   = c_sel;
    cmd_adr   = c_adr;
    cmd_dat   = c_dat;
    step();
    cmd_valid = 1'b0;
    s_we    = we;
    s_sel   = sel;
    s_adr   = adr;
    s_dat   = dato;
    stable  = 1'b1;
    cyc_len = 0;
    while (cyc === 1'b1 && cyc_len < 1000) begin
      if (stb !== 1'b1 || we !== s_we || sel !== s_sel ||
          adr !== s_adr || dato !== s_dat ||
          cmd_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0)
        stable = 1'b0;
      if (ack_en && w == 0) begin
        ack  = 1'b1;
        dati = ack_dat;
      end
      step();
      ack  = 1'b0;
      dati = 32'h0BAD_F00D;
      w--;
      cyc_len++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({cyc, stb, we, sel, adr, dato} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0",
               {cyc, stb, we, sel, adr, dato});
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, busy, txn} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0",
               {rsp_valid, rsp_err, rsp_dat, busy, txn});
    end
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b busy=%b want 1/0",
               cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st;
    run_cmd(1'b1, 4'hF, 32'h300F_FFF8, 32'hA5A5_1234, 1, 1'b1,
            32'h7777_7777, n, s_we, s_sel, s_adr, s_dat, st);
    checks++;
    if ({s_we, s_sel, s_adr, s_dat} !==
        {1'b1, 4'hF, 32'h300F_FFF8, 32'hA5A5_1234}) begin
      errors++;
      $display("FAIL wr_bus: got %h want %h",
               {s_we, s_sel, s_adr, s_dat},
               {1'b1, 4'hF, 32'h300F_FFF8, 32'hA5A5_1234});
    end
    checks++;
    if (n !== 2 || st !== 1'b1) begin
      errors++;
      $display("FAIL wr_cyc_len: got %0d stable=%b want 2/1", n, st);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 ||
        rsp_err !== 1'b0 || txn !== 16'd1) begin
      errors++;
      $display("FAIL wr_rsp: got v=%b d=%h e=%b n=%0d want 1/0/0/1",
               rsp_valid, rsp_dat, rsp_err, txn);
    end
    release_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: got v=%b rdy=%b busy=%b want 0/1/0",
               rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_read;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st;
    run_cmd(1'b0, 4'hF, 32'h300F_FFFC, 32'h1111_2222, 3, 1'b1,
            32'h0000_00C3, n, s_we, s_sel, s_adr, s_dat, st);
    checks++;
    if (s_we !== 1'b0 || s_adr !== 32'h300F_FFFC || s_dat !== 32'h0) begin
      errors++;
      $display("FAIL rd_bus: got we=%b a=%h d=%h want 0/300ffffc/0",
               s_we, s_adr, s_dat);
    end
    checks++;
    if (n !== 4 || st !== 1'b1) begin
      errors++;
      $display("FAIL rd_cyc_len: got %0d stable=%b want 4/1", n, st);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_00C3 ||
        rsp_err !== 1'b0 || txn !== 16'd2) begin
      errors++;
      $display("FAIL rd_rsp: got v=%b d=%h e=%b n=%0d want 1/c3/0/2",
               rsp_valid, rsp_dat, rsp_err, txn);
    end
    release_rsp();
  endtask

  task automatic test_timeout;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st;
    run_cmd(1'b0, 4'h3, 32'h3000_1000, 32'h0, 0, 1'b0,
            32'h0, n, s_we, s_sel, s_adr, s_dat, st);
    checks++;
    if (n !== 256 || st !== 1'b1 || cyc !== 1'b0) begin
      errors++;
      $display("FAIL tmo_cyc_len: got %0d stable=%b want 256/1", n, st);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF ||
        rsp_err !== 1'b1 || txn !== 16'd3) begin
      errors++;
      $display("FAIL tmo_rsp: got v=%b d=%h e=%b n=%0d want 1/deadbeef/1/3",
               rsp_valid, rsp_dat, rsp_err, txn);
    end
    release_rsp();
  endtask

  task automatic test_ack_at_expiry;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st;
    run_cmd(1'b0, 4'hF, 32'h3000_2000, 32'h0, 255, 1'b1,
            32'h5A5A_0077, n, s_we, s_sel, s_adr, s_dat, st);
    checks++;
    if (n !== 256 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_dat !== 32'h5A5A_0077 || txn !== 16'd4) begin
      errors++;
      $display("FAIL ack_expiry: got len=%0d v=%b e=%b d=%h n=%0d want 256/1/0/5a5a0077/4",
               n, rsp_valid, rsp_err, rsp_dat, txn);
    end
    release_rsp();
    ack  = 1'b1;
    dati = 32'h1234_5678;
    repeat (3) step();
    ack = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || txn !== 16'd4 ||
        busy !== 1'b0 || cyc !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got v=%b n=%0d busy=%b cyc=%b want 0/4/0/0",
               rsp_valid, txn, busy, cyc);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st, held;
    run_cmd(1'b0, 4'hF, 32'h3000_0040, 32'h0, 1, 1'b1,
            32'h1234_ABCD, n, s_we, s_sel, s_adr, s_dat, st);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_sel   = 4'h5;
    cmd_adr   = 32'h3000_0080;
    cmd_dat   = 32'hCAFE_0001;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_ABCD ||
          rsp_err !== 1'b0 || cmd_ready !== 1'b0 || cyc !== 1'b0)
        held = 1'b0;
      step();
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got stable=%b want 1", held);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b cyc=%b want 0/1/0",
               rsp_valid, cmd_ready, cyc);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (cyc !== 1'b1 || we !== 1'b1 || sel !== 4'h5 ||
        adr !== 32'h3000_0080 || dato !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL bp_next_cmd: got cyc=%b we=%b s=%h a=%h d=%h",
               cyc, we, sel, adr, dato);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || txn !== 16'd6) begin
      errors++;
      $display("FAIL bp_next_rsp: got v=%b d=%h n=%0d want 1/0/6",
               rsp_valid, rsp_dat, txn);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid;
    int n;
    logic s_we;
    logic [3:0] s_sel;
    logic [31:0] s_adr, s_dat;
    bit st, quiet;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_adr   = 32'h300F_FFF8;
    cmd_dat   = 32'h0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checks++;
    if (cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got cyc=%b want 1", cyc);
    end
    rst = 1'b1;
    step();
    checks++;
    if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0 ||
        txn !== 16'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got cyc=%b stb=%b busy=%b n=%0d v=%b",
               cyc, stb, busy, txn, rsp_valid);
    end
    rst = 1'b0;
    quiet = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b0 || cyc !== 1'b0) quiet = 1'b0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_rsp: got quiet=%b want 1", quiet);
    end
    run_cmd(1'b1, 4'hC, 32'h3000_0010, 32'h0000_BEEF, 1, 1'b1,
            32'h0, n, s_we, s_sel, s_adr, s_dat, st);
    checks++;
    if (n !== 2 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
        txn !== 16'd1 || s_dat !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL rst_after: got len=%0d v=%b e=%b n=%0d d=%h",
               n, rsp_valid, rsp_err, txn, s_dat);
    end
    release_rsp();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = '0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    ack       = 1'b0;
    dati      = 32'h0BAD_F00D;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_expiry();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
